imm_decode_stage: RTL

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_pkg.sv | 50 +++++
 rtl/imm_extract.sv | 123 ++++++++++++
 rtl/imm_decode_stage.sv | 103 ++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_pkg
// Description : Shared opcode, immediate-type and RVC constants for the
//               immediate decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // 32-bit base opcodes
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_op_imm32  = 7'b0011011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    // Bit positions inside the one-hot {j,u,b,s,i} type vector
    localparam int unsigned c_type_i = 0;
    localparam int unsigned c_type_s = 1;
    localparam int unsigned c_type_b = 2;
    localparam int unsigned c_type_u = 3;
    localparam int unsigned c_type_j = 4;

    // Compressed quadrants (ir[1:0]) and funct3 (ir[15:13])
    localparam logic [1:0] c_quad0    = 2'b00;
    localparam logic [1:0] c_quad1    = 2'b01;
    localparam logic [1:0] c_quad2    = 2'b10;
    localparam logic [2:0] c_c0_lw    = 3'b010;
    localparam logic [2:0] c_c0_sw    = 3'b110;
    localparam logic [2:0] c_c1_addi  = 3'b000;
    localparam logic [2:0] c_c1_jal   = 3'b001;
    localparam logic [2:0] c_c1_li    = 3'b010;
    localparam logic [2:0] c_c1_lui   = 3'b011;
    localparam logic [2:0] c_c1_j     = 3'b101;
    localparam logic [2:0] c_c1_beqz  = 3'b110;
    localparam logic [2:0] c_c1_bnez  = 3'b111;
    localparam logic [2:0] c_c2_lwsp  = 3'b010;
    localparam logic [2:0] c_c2_swsp  = 3'b110;

    function automatic logic [4:0] type_onehot(input int unsigned idx);
        return 5'b00001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
// Module      : imm_extract
// Description : Combinational immediate/type decode for one instruction word.
//               Compressed forms are decoded only when IMM_DECODE_RVC_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_ir,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_type,
    output logic            o_rvc
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extract: XLEN must be 32 or 64");
    end

    logic [31:0] w_imm32;
    logic [4:0]  w_type;
    logic        w_rvc;

    always_comb begin
        w_imm32 = '0;
        w_type  = '0;
        w_rvc   = 1'b0;
`ifdef IMM_DECODE_RVC_EN
        if (i_ir[1:0] != 2'b11) begin
            w_rvc = 1'b1;
            case (i_ir[1:0])
                c_quad0: begin
                    if (i_ir[15:13] == c_c0_lw || i_ir[15:13] == c_c0_sw) begin
                        w_imm32 = {25'b0, i_ir[5], i_ir[12:10], i_ir[6], 2'b00};
                        w_type  = type_onehot((i_ir[15:13] == c_c0_lw) ? c_type_i : c_type_s);
                    end
                end
                c_quad1: begin
                    case (i_ir[15:13])
                        c_c1_addi, c_c1_li: begin
                            w_imm32 = {{26{i_ir[12]}}, i_ir[12], i_ir[6:2]};
                            w_type  = type_onehot(c_type_i);
                        end
                        // rd==x2 in this slot is c.addi16sp, not c.lui
                        c_c1_lui: begin
                            if (i_ir[11:7] != 5'd2) begin
                                w_imm32 = {{14{i_ir[12]}}, i_ir[12], i_ir[6:2], 12'b0};
                                w_type  = type_onehot(c_type_u);
                            end
                        end
                        c_c1_jal, c_c1_j: begin
                            // On RV64 funct3=001 is c.addiw, which is not decoded here
                            if (i_ir[15:13] == c_c1_j || XLEN == 32) begin
                                w_imm32 = {{20{i_ir[12]}}, i_ir[12], i_ir[8], i_ir[10:9], i_ir[6],
                                           i_ir[7], i_ir[2], i_ir[11], i_ir[5:3], 1'b0};
                                w_type  = type_onehot(c_type_j);
                            end
                        end
                        c_c1_beqz, c_c1_bnez: begin
                            w_imm32 = {{23{i_ir[12]}}, i_ir[12], i_ir[6:5], i_ir[2],
                                       i_ir[11:10], i_ir[4:3], 1'b0};
                            w_type  = type_onehot(c_type_b);
                        end
                        default: ;
                    endcase
                end
                c_quad2: begin
                    if (i_ir[15:13] == c_c2_lwsp) begin
                        w_imm32 = {24'b0, i_ir[3:2], i_ir[12], i_ir[6:4], 2'b00};
                        w_type  = type_onehot(c_type_i);
                    end else if (i_ir[15:13] == c_c2_swsp) begin
                        w_imm32 = {24'b0, i_ir[8:7], i_ir[12:9], 2'b00};
                        w_type  = type_onehot(c_type_s);
                    end
                end
                default: ;
            endcase
        end else
`endif
        begin
            case (i_ir[6:0])
                c_op_load, c_op_imm, c_op_jalr, c_op_system: begin
                    w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
                    w_type  = type_onehot(c_type_i);
                end
                c_op_imm32: begin
                    if (XLEN == 64) begin
                        w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
                        w_type  = type_onehot(c_type_i);
                    end
                end
                c_op_store: begin
                    w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
                    w_type  = type_onehot(c_type_s);
                end
                c_op_branch: begin
                    w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
                    w_type  = type_onehot(c_type_b);
                end
                c_op_lui, c_op_auipc: begin
                    w_imm32 = {i_ir[31:12], 12'b0};
                    w_type  = type_onehot(c_type_u);
                end
                c_op_jal: begin
                    w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
                    w_type  = type_onehot(c_type_j);
                end
                default: ;
            endcase
        end
    end

    // Zero-extended forms already carry a clear bit 31, so one sign-extend covers all
    assign o_imm  = XLEN'($signed(w_imm32));
    assign o_type = w_type;
    assign o_rvc  = w_rvc;

endmodule
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_decode_stage
// Description : Immediate decode pipeline stage with a 2-entry skid buffer.
//               Define IMM_DECODE_RVC_EN to enable compressed decode.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_ir,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_type,
    output logic            out_rvc
);

    // Entry layout: {ir, imm, type, rvc}
    localparam int c_ew = 32 + XLEN + 5 + 1;

    logic [XLEN-1:0] w_dec_imm;
    logic [4:0]      w_dec_type;
    logic            w_dec_rvc;
    logic [c_ew-1:0] w_dec_entry;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_ir   (in_ir),
        .o_imm  (w_dec_imm),
        .o_type (w_dec_type),
        .o_rvc  (w_dec_rvc)
    );

    assign w_dec_entry = {in_ir, w_dec_imm, w_dec_type, w_dec_rvc};

    logic            r_out_valid;
    logic [c_ew-1:0] r_out_entry;
    logic            r_skid_valid;
    logic [c_ew-1:0] r_skid_entry;
    logic            r_in_ready;

    logic            w_in_fire;
    logic            w_out_valid_nxt;
    logic [c_ew-1:0] w_out_entry_nxt;
    logic            w_skid_valid_nxt;
    logic [c_ew-1:0] w_skid_entry_nxt;

    assign w_in_fire = in_valid && r_in_ready;

    always_comb begin
        w_out_valid_nxt  = r_out_valid;
        w_out_entry_nxt  = r_out_entry;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_entry_nxt = r_skid_entry;
        if (r_skid_valid) begin
            // in_ready is low here, so only the promotion can happen
            if (out_ready) begin
                w_out_entry_nxt  = r_skid_entry;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (!r_out_valid || out_ready) begin
            w_out_valid_nxt = w_in_fire;
            if (w_in_fire) begin
                w_out_entry_nxt = w_dec_entry;
            end
        end else if (w_in_fire) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_entry_nxt = w_dec_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_entry  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_entry <= '0;
            r_in_ready   <= 1'b1;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out_entry  <= w_out_entry_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_entry <= w_skid_entry_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ir    = r_out_entry[c_ew-1 -: 32];
    assign out_imm   = r_out_entry[XLEN+5 : 6];
    assign out_type  = r_out_entry[5:1];
    assign out_rvc   = r_out_entry[0];

endmodule
`default_nettype wire
